// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: FSM states and ALU op codes shared by the sequencer and its ALU.
package alu_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
endpackage

// File: rtl/alu_sequencer_alu.sv
// alu_sequencer_alu: combinational ALU; any op with bit 2 set subtracts, carry is borrow for SUB.
module alu_sequencer_alu
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] data,
    output logic             carry
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        data  = op[2]         ? diff[WIDTH-1:0] :
                op == OP_ADD  ? sum[WIDTH-1:0]  :
                op == OP_XOR  ? a ^ b           :
                op == OP_OR   ? a | b           :
                op == OP_AND  ? a & b           : '0;
        carry = op[2] ? diff[WIDTH] : (op == OP_ADD) && sum[WIDTH];
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: one-command-at-a-time register-file ALU sequencer (IDLE -> ISSUE -> CAPTURE -> RESP).
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    localparam int IW   = NREG > 1 ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [IW-1:0]    cmd_dst,
    input  logic [IW-1:0]    cmd_srca,
    input  logic [IW-1:0]    cmd_srcb,
    input  logic             cmd_use_imm,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry
);
    state_t           state, state_nxt;
    logic             alive;
    logic [2:0]       op_q;
    logic [IW-1:0]    dst_q;
    logic [WIDTH-1:0] a_q, b_q, rd_a, rd_b, alu_data;
    logic             alu_carry, cmd_fire;
    logic [WIDTH-1:0] regs [NREG];

    // alive holds cmd_ready low until the first edge after reset release
    always_comb begin
        rd_a      = int'(cmd_srca) < NREG ? regs[cmd_srca] : '0;
        rd_b      = int'(cmd_srcb) < NREG ? regs[cmd_srcb] : '0;
        cmd_ready = alive && state == IDLE;
        rsp_valid = state == RESP;
        cmd_fire  = cmd_valid && cmd_ready;
        state_nxt = state == IDLE    ? (cmd_fire ? ISSUE : IDLE) :
                    state == ISSUE   ? CAPTURE :
                    state == CAPTURE ? RESP :
                    (rsp_ready ? IDLE : RESP);
    end

    alu_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
        .op(op_q), .a(a_q), .b(b_q), .data(alu_data), .carry(alu_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alive     <= 1'b0;
            op_q      <= '0;
            dst_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
            if (cmd_fire) begin
                op_q  <= cmd_op;
                dst_q <= cmd_dst;
                a_q   <= rd_a;
                b_q   <= cmd_use_imm ? cmd_imm : rd_b;
            end
            if (state == CAPTURE) begin
                rsp_data  <= alu_data;
                rsp_carry <= alu_carry;
                if (int'(dst_q) < NREG) regs[dst_q] <= alu_data;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench with hand-computed results for alu_sequencer (WIDTH=4, NREG=4).
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready, cmd_use_imm, rsp_valid, rsp_ready, rsp_carry;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
    logic [3:0] cmd_imm, rsp_data;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n;

    alu_sequencer #(.WIDTH(4), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_carry(rsp_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                         input logic [1:0] sb, input logic ui, input logic [3:0] imm);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
        cmd_use_imm = ui; cmd_imm = imm;
    endtask

    // Latency counts edges from the accepting edge (inclusive) until rsp_valid is seen.
    task automatic run(input string tag, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic ui,
                       input logic [3:0] imm, input logic [3:0] ed, input logic ec);
        int k;
        chk({tag, ".ready"}, cmd_ready, 1);
        drive(op, dst, sa, sb, ui, imm);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 10) begin @(posedge clk); #1; k++; end
        chk({tag, ".lat"}, k, 3);
        chk({tag, ".data"}, rsp_data, ed);
        chk({tag, ".carry"}, rsp_carry, ec);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".idle"}, rsp_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        drive(3'b000, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0);
        cmd_valid = 1'b0;
        #12;
        chk("rst.cmd_ready", cmd_ready, 0);
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.rsp_data", rsp_data, 0);
        chk("rst.rsp_carry", rsp_carry, 0);
        #10 rst_n = 1'b1;
        #1 chk("rel.ready_low", cmd_ready, 0);
        @(posedge clk); #1;
        chk("rel.ready_high", cmd_ready, 1);

        run("add_r1",   3'b011, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5,  4'd5,  1'b0);
        run("add_r2",   3'b011, 2'd2, 2'd1, 2'd0, 1'b1, 4'd9,  4'd14, 1'b0);
        run("rd_r2",    3'b011, 2'd3, 2'd2, 2'd0, 1'b1, 4'd0,  4'd14, 1'b0);
        run("set12",    3'b011, 2'd1, 2'd0, 2'd0, 1'b1, 4'd12, 4'd12, 1'b0);
        run("add_cy",   3'b011, 2'd3, 2'd1, 2'd0, 1'b1, 4'd7,  4'd3,  1'b1);
        run("set3",     3'b011, 2'd1, 2'd0, 2'd0, 1'b1, 4'd3,  4'd3,  1'b0);
        run("sub_brw",  3'b100, 2'd2, 2'd1, 2'd0, 1'b1, 4'd5,  4'd14, 1'b1);
        run("r0_self",  3'b011, 2'd0, 2'd0, 2'd0, 1'b1, 4'd5,  4'd5,  1'b0);
        run("sub_reg",  3'b100, 2'd3, 2'd0, 2'd1, 1'b0, 4'd0,  4'd2,  1'b0);
        run("sub_111",  3'b111, 2'd3, 2'd1, 2'd0, 1'b1, 4'd5,  4'd14, 1'b1);
        run("clr_r1",   3'b000, 2'd1, 2'd0, 2'd0, 1'b1, 4'd0,  4'd0,  1'b0);
        run("set1010",  3'b001, 2'd1, 2'd1, 2'd0, 1'b1, 4'hA,  4'hA,  1'b0);
        run("and",      3'b000, 2'd2, 2'd1, 2'd0, 1'b1, 4'h6,  4'h2,  1'b0);
        run("or",       3'b001, 2'd2, 2'd1, 2'd0, 1'b1, 4'h6,  4'hE,  1'b0);
        run("xor",      3'b010, 2'd2, 2'd1, 2'd0, 1'b1, 4'h6,  4'hC,  1'b0);
        run("dst_srca", 3'b011, 2'd1, 2'd1, 2'd1, 1'b0, 4'd0,  4'h4,  1'b1);

        // Backpressure: result held while rsp_ready is low and a stray command is offered.
        drive(3'b010, 2'd2, 2'd1, 2'd0, 1'b1, 4'h3);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("hold.lat", n, 3);
        chk("hold.data0", rsp_data, 4'h7);
        drive(3'b011, 2'd0, 2'd0, 2'd0, 1'b1, 4'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold.valid", rsp_valid, 1);
            chk("hold.data", rsp_data, 4'h7);
            chk("hold.carry", rsp_carry, 0);
            chk("hold.cmd_ready", cmd_ready, 0);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("hold.release_valid", rsp_valid, 0);
        chk("hold.release_ready", cmd_ready, 1);
        run("r0_kept",  3'b011, 2'd3, 2'd0, 2'd0, 1'b1, 4'd0,  4'd5,  1'b0);

        // Reset while in CAPTURE with a carry-producing add in flight.
        drive(3'b011, 2'd3, 2'd0, 2'd0, 1'b1, 4'd15);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.cmd_ready", cmd_ready, 0);
        chk("midrst.rsp_valid", rsp_valid, 0);
        chk("midrst.rsp_data", rsp_data, 0);
        chk("midrst.rsp_carry", rsp_carry, 0);
        #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) n++;
        end
        rsp_ready = 1'b0;
        chk("midrst.no_rsp", n, 0);
        chk("midrst.ready", cmd_ready, 1);
        run("midrst_r3", 3'b011, 2'd0, 2'd3, 2'd0, 1'b1, 4'd0,  4'd0,  1'b0);
        run("midrst_r0", 3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 4'd0,  4'd0,  1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
